i2c_slave: RTL
==============

// Module: i2c_slave
// PURPOSE
//  I2C target (slave) sitting downstream of the master on the sclk/sda link.
//  Detects START/STOP, matches a 7-bit address, then receives bytes (master write)
//  or transmits bytes (master read). Byte-level data is exchanged with local logic
//  through rx_data/rx_valid and tx_data/tx_load. Serves as bus partner for master
//  bring-up and as the base for register-file peripherals.
// PARAMETERS
//  ADDR   7'h50  own 7-bit bus address
// PORTS
//  clk       in   1  system clock; all logic on posedge clk
//  rst       in   1  synchronous, active-high reset
//  sclk      in   1  bus clock from master
//  sda_in    in   1  bus data as seen on the wire (master sda_out)
//  sda_out   out  1  slave drive: 0 = pull low, 1 = release
//  tx_data   in   8  byte to return on a read; sampled when tx_load pulses
//  tx_load   out  1  1-cycle pulse: tx_data captured, present next byte
//  rx_data   out  8  last byte received on a write
//  rx_valid  out  1  1-cycle pulse: rx_data updated
//  rw        out  1  R/W bit of last matched address (1 = read)
//  state     out  3  current FSM state (encoding below)
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): sda_out=1, state=IDLE, rx_data=0, rx_valid=0,
//   tx_load=0, rw=0, bit counter=0, synchronisers preset to 1.
//  Input sync: sclk, sda_in each through 2 flops; prior-sample flop for edges.
//   Pin change -> edge seen on 3rd posedge clk. All events below use synced values.
//  Events: SCLK_R = sclk 0->1; SCLK_F = sclk 1->0;
//   START = sda 1->0 while sclk=1; STOP = sda 0->1 while sclk=1.
//  States: IDLE=0 ADDR=1 ACK_ADDR=2 RX=3 ACK_RX=4 TX=5 ACK_TX=6.
//  Priority: STOP > START > bit events. START/STOP take effect same cycle detected.
//  START from any state (repeated start): -> ADDR, counter=0, sda_out=1.
//  STOP from any state: -> IDLE, sda_out=1; partial byte discarded, no rx_valid.
//  IDLE: sda_out=1; ignore sclk edges.
//  ADDR: on SCLK_R shift sda into shift reg MSB-first; counter++. After 8th bit
//   compare [7:1] with ADDR. Match: latch rw=[0]; at next SCLK_F sda_out=0,
//   -> ACK_ADDR. Mismatch: -> IDLE (stay released until next START).
//  ACK_ADDR: hold sda_out=0 through 9th SCLK_R; at following SCLK_F, counter=0 and:
//   rw=0 -> RX, sda_out=1. rw=1 -> TX: tx_load=1 that cycle, tx_data into
//   shift reg, sda_out = tx_data[7] the same cycle.
//  RX: shift on SCLK_R. On 8th bit: rx_data<=shift value, rx_valid=1 one cycle.
//   Next SCLK_F: sda_out=0 -> ACK_RX. Slave always ACKs data bytes.
//  ACK_RX: hold sda_out=0 to next SCLK_F; then sda_out=1, counter=0 -> RX.
//  TX: each SCLK_F after the first bit drives next bit MSB-first; after 8th bit
//   its SCLK_F releases sda_out=1 -> ACK_TX.
//  ACK_TX: at 9th SCLK_R sample sda: 0 (ACK) -> at next SCLK_F tx_load pulse,
//   reload, drive MSB, -> TX. 1 (NACK) -> IDLE, sda_out=1.
//  sda_out only changes on SCLK_F or START/STOP, never while sclk high.
//  Reset mid-transfer: immediate return to reset values; bus released same cycle.
//  Unused encoding 7 -> IDLE next cycle.
// TESTING
//  1 Write: START, addr 0x50+W, data 0x5A, STOP -> ACK on 9th clk both bytes;
//    rx_valid once, rx_data=0x5A; rw=0; final state IDLE.
//  2 Read: START, 0x50+R, tx_data=0xF6, master NACK -> sda_out bits 1,1,1,1,0,1,1,0;
//    tx_load once; state 5->6->0.
//  3 Mismatch: START, addr 0x51+W, 8 data clocks -> sda_out stays 1 throughout,
//    no rx_valid, state IDLE after address.
//  4 Two-byte read with ACK then NACK, tx_data 0xA5 then 0x3C -> two tx_load
//    pulses, both bytes on sda, then IDLE.
//  5 Repeated START after 3 data bits of a write, then 0x50+R -> no rx_valid,
//    state ADDR, read proceeds normally.
//  6 rst=1 while slave drives ACK low -> sda_out=1, state=0 on next posedge clk.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, byte receive with ACK and
// byte transmit with master ACK/NACK handling. Bus pins are synchronised to clk.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAddr    = 3'd1,
    StAckAddr = 3'd2,
    StRx      = 3'd3,
    StAckRx   = 3'd4,
    StTx      = 3'd5,
    StAckTx   = 3'd6
  } state_e;

  state_e     state_q;
  // [0] first flop, [1] synchronised value, [2] previous synchronised value
  logic [2:0] sclk_sync_q, sda_sync_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q;
  logic       sda_out_q, tx_load_q, rx_valid_q, rw_q;
  logic [7:0] rx_data_q;

  logic sclk_rise, sclk_fall, start_det, stop_det, sda_s;

  assign sda_s     = sda_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign start_det = sclk_sync_q[1] & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det  = sclk_sync_q[1] & ~sda_sync_q[2] & sda_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 3'b111;
      sda_sync_q  <= 3'b111;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      sda_sync_q  <= {sda_sync_q[1:0], sda_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      sda_out_q  <= 1'b1;
      tx_load_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rw_q       <= 1'b0;
    end else begin
      tx_load_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      if (stop_det) begin
        state_q   <= StIdle;
        sda_out_q <= 1'b1;
      end else if (start_det) begin
        state_q   <= StAddr;
        cnt_q     <= 4'd0;
        sda_out_q <= 1'b1;
      end else begin
        case (state_q)
          StIdle: sda_out_q <= 1'b1;
          StAddr: begin
            if (sclk_rise) begin
              shift_q <= {shift_q[6:0], sda_s};
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                if (shift_q[6:0] == ADDR) rw_q <= sda_s;
                else state_q <= StIdle;
              end
            end else if (sclk_fall && cnt_q == 4'd8) begin
              sda_out_q <= 1'b0;
              state_q   <= StAckAddr;
            end
          end
          StAckAddr: begin
            if (sclk_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) begin
                state_q   <= StTx;
                tx_load_q <= 1'b1;
                // Remaining bits are kept MSB-aligned; sda_out already carries bit 7
                shift_q   <= {tx_data[6:0], 1'b1};
                sda_out_q <= tx_data[7];
              end else begin
                state_q   <= StRx;
                sda_out_q <= 1'b1;
              end
            end
          end
          StRx: begin
            if (sclk_rise) begin
              shift_q <= {shift_q[6:0], sda_s};
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                rx_data_q  <= {shift_q[6:0], sda_s};
                rx_valid_q <= 1'b1;
              end
            end else if (sclk_fall && cnt_q == 4'd8) begin
              sda_out_q <= 1'b0;
              state_q   <= StAckRx;
            end
          end
          StAckRx: begin
            if (sclk_fall) begin
              sda_out_q <= 1'b1;
              cnt_q     <= 4'd0;
              state_q   <= StRx;
            end
          end
          StTx: begin
            if (sclk_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (sclk_fall) begin
              if (cnt_q == 4'd8) begin
                sda_out_q <= 1'b1;
                state_q   <= StAckTx;
              end else begin
                sda_out_q <= shift_q[7];
                shift_q   <= {shift_q[6:0], 1'b1};
              end
            end
          end
          StAckTx: begin
            if (sclk_rise) begin
              if (sda_s) begin
                state_q   <= StIdle;
                sda_out_q <= 1'b1;
              end else begin
                cnt_q <= 4'd9;  // master ACKed: reload on the next falling edge
              end
            end else if (sclk_fall && cnt_q == 4'd9) begin
              cnt_q     <= 4'd0;
              tx_load_q <= 1'b1;
              shift_q   <= {tx_data[6:0], 1'b1};
              sda_out_q <= tx_data[7];
              state_q   <= StTx;
            end
          end
          default: begin
            state_q   <= StIdle;
            sda_out_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_out  = sda_out_q;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rw       = rw_q;
  assign state    = state_q;

endmodule
